// File: rtl/nec_ir_tx.sv
// NEC infrared transmitter: sends {~cmd, cmd, ~addr, addr} LSB first as a full
// NEC frame (lead mark/space, 32 pulse-distance bits, stop mark, idle gap).
`timescale 1ns/1ps
module nec_ir_tx #(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned CARRIER_FREQ = 38_000,
  parameter bit          CARRIER_EN   = 1'b1,
  parameter int unsigned GAP_US       = 40_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_addr,
  input  logic [7:0] tx_cmd,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       ir_env,
  output logic       ir_out
);

  localparam logic [31:0] US           = 32'(CLK_FREQ / 1_000_000);
  localparam logic [31:0] T_LEAD_MARK  = 32'd9000 * US;
  localparam logic [31:0] T_LEAD_SPACE = 32'd4500 * US;
  localparam logic [31:0] T_BIT_MARK   = 32'd560 * US;
  localparam logic [31:0] T_ZERO_SPACE = 32'd560 * US;
  localparam logic [31:0] T_ONE_SPACE  = 32'd1690 * US;
  localparam logic [31:0] T_GAP        = 32'(GAP_US) * US;
  localparam logic [31:0] HALF         = 32'(CLK_FREQ / (2 * CARRIER_FREQ));

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_STOP_MARK, S_GAP
  } state_t;

  state_t      state, state_d;
  logic [31:0] cnt, cnt_d;
  logic [31:0] ccnt, ccnt_d;
  logic [31:0] shreg, shreg_d;
  logic [5:0]  bit_cnt, bit_cnt_d;
  logic [31:0] dur;
  logic        at_end, carrier, car_d, env_d, done_d;

  // Duration of the current state; a 1 bit gets the long space.
  always_comb begin
    dur = T_LEAD_MARK;
    case (state)
      S_LEAD_SPACE:             dur = T_LEAD_SPACE;
      S_BIT_MARK, S_STOP_MARK:  dur = T_BIT_MARK;
      S_BIT_SPACE:              dur = shreg[0] ? T_ONE_SPACE : T_ZERO_SPACE;
      S_GAP:                    dur = T_GAP;
      default:                  dur = T_LEAD_MARK;
    endcase
  end

  assign at_end = (cnt == dur - 32'd1);

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    bit_cnt_d = bit_cnt;
    done_d    = 1'b0;
    case (state)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (tx_start) begin
          shreg_d = {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
          state_d = S_LEAD_MARK;
        end
      end
      S_LEAD_MARK:  if (at_end) state_d = S_LEAD_SPACE;
      S_LEAD_SPACE: if (at_end) state_d = S_BIT_MARK;
      S_BIT_MARK:   if (at_end) state_d = S_BIT_SPACE;
      S_BIT_SPACE: begin
        if (at_end) begin
          shreg_d   = {1'b0, shreg[31:1]};
          bit_cnt_d = bit_cnt + 6'd1;
          state_d   = (bit_cnt == 6'd31) ? S_STOP_MARK : S_BIT_MARK;
        end
      end
      S_STOP_MARK:  if (at_end) state_d = S_GAP;
      S_GAP: begin
        if (at_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default:      state_d = S_IDLE;
    endcase

    cnt_d = (state_d != state || state == S_IDLE) ? '0 : cnt + 32'd1;
    env_d = (state_d == S_LEAD_MARK) || (state_d == S_BIT_MARK) || (state_d == S_STOP_MARK);

    // Carrier restarts high on each mark entry and is parked low during spaces.
    car_d  = 1'b0;
    ccnt_d = '0;
    if (env_d && state_d != state) begin
      car_d = 1'b1;
    end else if (env_d) begin
      car_d = carrier;
      if (ccnt == HALF - 32'd1) begin
        car_d = ~carrier;
      end else begin
        ccnt_d = ccnt + 32'd1;
      end
    end
  end

  // Outputs are registered from next-state values so they line up with the state.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ccnt    <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      carrier <= 1'b0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      ir_env  <= 1'b0;
      ir_out  <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      ccnt    <= ccnt_d;
      shreg   <= shreg_d;
      bit_cnt <= bit_cnt_d;
      carrier <= car_d;
      tx_busy <= (state_d != S_IDLE);
      tx_done <= done_d;
      ir_env  <= env_d;
      ir_out  <= CARRIER_EN ? (env_d & car_d) : env_d;
    end
  end

endmodule

// File: tb/tb_nec_ir_tx.sv
// Scoreboard bench for nec_ir_tx: a segment-list model of each NEC frame is
// queued at stimulus time and a negedge monitor measures the envelope against it.
`timescale 1ns/1ps
module tb_nec_ir_tx;

  localparam int unsigned CLK_FREQ = 1_000_000;
  localparam int unsigned GAP_US   = 1000;
  localparam int unsigned US       = CLK_FREQ / 1_000_000;
  localparam int unsigned H        = CLK_FREQ / (2 * 38_000);
  localparam int unsigned THRESH   = (560 + 1690) / 2 * US;

  typedef enum {K_LEAD_M, K_LEAD_S, K_BIT_M, K_BIT_S, K_STOP_M, K_GAP} kind_e;
  typedef struct {kind_e kind; bit level; int unsigned len;} seg_t;
  typedef struct {logic [31:0] word; longint total;} frame_t;

  logic clk = 1'b0;
  logic rst_n, tx_start;
  logic [7:0] tx_addr, tx_cmd;
  logic tx_busy, tx_done, ir_env, ir_out;
  logic tx_busy_c, tx_done_c, ir_env_c, ir_out_c;

  always #5 clk = ~clk;

  nec_ir_tx #(.CLK_FREQ(CLK_FREQ), .CARRIER_FREQ(38_000), .CARRIER_EN(1'b0), .GAP_US(GAP_US)) u_dut (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_addr(tx_addr), .tx_cmd(tx_cmd),
    .tx_busy(tx_busy), .tx_done(tx_done), .ir_env(ir_env), .ir_out(ir_out));

  nec_ir_tx #(.CLK_FREQ(CLK_FREQ), .CARRIER_FREQ(38_000), .CARRIER_EN(1'b1), .GAP_US(GAP_US)) u_car (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_addr(tx_addr), .tx_cmd(tx_cmd),
    .tx_busy(tx_busy_c), .tx_done(tx_done_c), .ir_env(ir_env_c), .ir_out(ir_out_c));

  seg_t   seg_q[$];
  frame_t frame_q[$];
  int n_checks = 0, n_fail = 0;
  int done_cnt = 0, seg_done = 0;
  int out_err = 0, car_err = 0;
  int unsigned busy_low_last = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference model: a frame is a list of (level, length) segments.
  task automatic push_frame(input logic [7:0] a, input logic [7:0] c,
                            output longint total, output int unsigned bit10_ofs);
    seg_t fr[$];
    logic [31:0] w;
    w = {~c, c, ~a, a};
    total = 0;
    bit10_ofs = 0;
    fr.push_back('{K_LEAD_M, 1'b1, 9000 * US});
    fr.push_back('{K_LEAD_S, 1'b0, 4500 * US});
    for (int i = 0; i < 32; i++) begin
      if (i == 10) begin
        foreach (fr[k]) bit10_ofs += fr[k].len;
      end
      fr.push_back('{K_BIT_M, 1'b1, 560 * US});
      fr.push_back('{K_BIT_S, 1'b0, (w[i] ? 1690 : 560) * US});
    end
    fr.push_back('{K_STOP_M, 1'b1, 560 * US});
    fr.push_back('{K_GAP, 1'b0, GAP_US * US});
    foreach (fr[k]) begin
      total += fr[k].len;
      seg_q.push_back(fr[k]);
    end
    frame_q.push_back('{w, total});
  endtask

  // Monitor: measures run lengths of the envelope and compares with the model.
  initial begin : monitor
    bit lvl = 1'b0, busy_prev = 1'b0, prev_env_c = 1'b0, exp_car;
    int unsigned run = 0, mpos = 0, busy_low_run = 0;
    longint now = 0, start = 0;
    logic [31:0] dec = '0;
    seg_t s;
    frame_t f;
    forever begin
      @(negedge clk);
      now++;
      if (tx_busy) begin
        if (!busy_prev) busy_low_last = busy_low_run;
        busy_low_run = 0;
      end else begin
        busy_low_run++;
      end
      busy_prev = tx_busy;
      if (!rst_n) begin
        seg_q.delete();
        frame_q.delete();
        lvl = 1'b0;
        run = 0;
        dec = '0;
        prev_env_c = 1'b0;
        continue;
      end
      if (ir_out !== ir_env || ir_env_c !== ir_env || tx_busy_c !== tx_busy || tx_done_c !== tx_done)
        out_err++;
      mpos = (ir_env_c && !prev_env_c) ? 0 : mpos + 1;
      exp_car = ir_env_c && ((mpos / H) % 2 == 0);
      if (ir_out_c !== exp_car) car_err++;
      prev_env_c = ir_env_c;

      if (ir_env === lvl) begin
        run++;
      end else begin
        if (lvl) begin
          check(seg_q.size() > 0 && seg_q[0].level, "mark_expected", seg_q.size(), 1);
        end
        if (seg_q.size() > 0 && seg_q[0].level == lvl && seg_q[0].kind != K_GAP) begin
          s = seg_q.pop_front();
          seg_done++;
          check(run == s.len, s.kind.name(), run, s.len);
          if (s.kind == K_LEAD_M) begin
            start = now - run;
            dec = '0;
          end
          if (s.kind == K_BIT_S) dec = {(run > THRESH), dec[31:1]};
        end
        lvl = ir_env;
        run = 1;
      end

      if (tx_done === 1'b1) begin
        done_cnt++;
        check(frame_q.size() > 0 && seg_q.size() > 0 && seg_q[0].kind == K_GAP,
              "done_expected", frame_q.size(), 1);
        if (frame_q.size() > 0 && seg_q.size() > 0 && seg_q[0].kind == K_GAP) begin
          s = seg_q.pop_front();
          f = frame_q.pop_front();
          seg_done++;
          check(lvl == 1'b0 && run - 1 == s.len, "gap_len", run - 1, s.len);
          check(dec == f.word, "frame_word", dec, f.word);
          check(now - start == f.total, "done_latency", now - start, f.total);
          check(out_err == 0, "out_match", out_err, 0);
          check(car_err == 0, "carrier", car_err, 0);
        end
      end
    end
  end

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  // Issues a one-cycle tx_start pulse; returns on the first lead-mark sample.
  task automatic start_frame(input logic [7:0] a, input logic [7:0] c,
                             output longint total, output int unsigned bit10_ofs);
    @(posedge clk); #1;
    tx_addr = a; tx_cmd = c; tx_start = 1'b1;
    push_frame(a, c, total, bit10_ofs);
    @(negedge clk);
    check(tx_busy == 1'b0 && ir_env == 1'b0, "idle_before_accept", {tx_busy, ir_env}, 0);
    @(posedge clk); #1;
    tx_start = 1'b0;
    @(negedge clk);
    check(tx_busy == 1'b1 && ir_env == 1'b1, "busy_env_after_accept", {tx_busy, ir_env}, 3);
  endtask

  initial begin : watchdog
    #(300_000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    longint tot_r, tot_a, tot_b;
    int unsigned ofs_r, ofs_a, ofs_b, seg_before;
    logic [7:0] a, c;
    rst_n = 1'b0; tx_start = 1'b0; tx_addr = '0; tx_cmd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({tx_busy, tx_done, ir_env, ir_out} == 4'b0, "reset_outputs",
          {tx_busy, tx_done, ir_env, ir_out}, 0);
    check({tx_busy_c, tx_done_c, ir_env_c, ir_out_c} == 4'b0, "reset_outputs_car",
          {tx_busy_c, tx_done_c, ir_env_c, ir_out_c}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Frame aborted by a one-cycle reset inside bit 10's mark.
    start_frame(8'h00, 8'h45, tot_r, ofs_r);
    repeat (ofs_r + 100) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check(ir_env == 1'b1, "in_bit10_mark", ir_env, 1);
    @(posedge clk);
    @(negedge clk);
    check({tx_busy, ir_env, ir_out, ir_out_c} == 4'b0, "reset_mid_frame",
          {tx_busy, ir_env, ir_out, ir_out_c}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (200) @(posedge clk);
    sync();
    check(done_cnt == 0, "no_done_after_reset", done_cnt, 0);
    check(tx_busy == 1'b0, "idle_after_reset", tx_busy, 0);

    // Full random frame, an ignored start during lead space, then a back-to-back start.
    a = 8'($urandom);
    c = 8'($urandom);
    start_frame(a, c, tot_a, ofs_a);
    repeat (9000 * US + 100) @(posedge clk);
    #1 tx_addr = ~a; tx_cmd = ~c; tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    @(negedge clk);
    check(ir_env == 1'b0 && tx_busy == 1'b1, "ignored_in_lead_space", {ir_env, tx_busy}, 1);
    repeat (int'(tot_a) - int'(GAP_US * US) + 500 - (9000 * US + 101)) @(posedge clk);
    #1 tx_addr = 8'hA5; tx_cmd = 8'h3C; tx_start = 1'b1;
    push_frame(8'hA5, 8'h3C, tot_b, ofs_b);
    for (int i = 0; i < 2000 && done_cnt == 0; i++) sync();
    check(done_cnt == 1, "single_done", done_cnt, 1);
    @(posedge clk); #1;
    tx_start = 1'b0;
    sync();
    check(tx_busy == 1'b1 && ir_env == 1'b1, "b2b_started", {tx_busy, ir_env}, 3);
    check(busy_low_last == 1, "b2b_busy_low", busy_low_last, 1);
    seg_before = seg_done;
    repeat (13500 * US + 4500 * US + 200) @(posedge clk);
    sync();
    check(seg_done - seg_before >= 6, "b2b_segments", seg_done - seg_before, 6);
    check(done_cnt == 1, "no_extra_done", done_cnt, 1);
    check(out_err == 0, "out_match_final", out_err, 0);
    check(car_err == 0, "carrier_final", car_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
